enc16to4_seq: RTL

- Sequential 16-to-4 encoder, the inverse direction of the team's 4-to-16 one-hot path decoder.
- Captures a 16-bit path vector, which may have several bits set.
- Emits the 4-bit select code of each set bit, one per valid/ready handshake, lowest index first.
- Sits between request-line sources and any consumer that drives a sel4to16-style decoder.

---
 rtl/enc16to4_seq_pkg.sv | 24 ++
 rtl/enc16to4_seq_pri.sv | 61 ++++++
 rtl/enc16to4_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/enc16to4_seq_pkg.sv
// enc16to4_seq_pkg
//   Shared constants and helpers for the sequential 16-to-4 encoder.
//   LIMIT  : select code width in bits
//   PATHS  : path vector width (2**LIMIT)
//   IDLE/EMIT : FSM state encodings
//   popcount(): number of set bits in a PATHS-wide vector, LIMIT+1 bits wide
package enc16to4_seq_pkg;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned PATHS = 2 ** LIMIT;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    function automatic logic [LIMIT:0] popcount(input logic [PATHS-1:0] v);
        logic [LIMIT:0] n;
        n = '0;
        for (int unsigned i = 0; i < PATHS; i++) begin
            n = n + {{LIMIT{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/enc16to4_seq_pri.sv
// enc16to4_pri
//   Combinational lowest-set-bit priority encoder, 16 bits in.
//   vec : input vector
//   idx : index of the lowest set bit (0 when vec is zero)
//   nz  : vec has at least one bit set
//   Built from two 8-to-3 halves: the low half wins; the high half adds 8.
module enc16to4_pri
    import enc16to4_seq_pkg::*;
(
    input  logic [PATHS-1:0] vec,
    output logic [LIMIT-1:0] idx,
    output logic             nz
);

    localparam int unsigned HALF = PATHS / 2;

    logic [HALF-1:0]  lo_vec;
    logic [HALF-1:0]  hi_vec;
    logic [LIMIT-2:0] lo_idx;
    logic [LIMIT-2:0] hi_idx;
    logic             lo_nz;
    logic             hi_nz;

    assign lo_vec = vec[HALF-1:0];
    assign hi_vec = vec[PATHS-1:HALF];

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        lo_idx = '0;
        lo_nz  = 1'b0;
        for (int unsigned i = HALF; i > 0; i--) begin
            if (lo_vec[i-1]) begin
                lo_idx = (LIMIT-1)'(i - 1);
                lo_nz  = 1'b1;
            end
        end
    end

    always_comb begin
        hi_idx = '0;
        hi_nz  = 1'b0;
        for (int unsigned i = HALF; i > 0; i--) begin
            if (hi_vec[i-1]) begin
                hi_idx = (LIMIT-1)'(i - 1);
                hi_nz  = 1'b1;
            end
        end
    end

    always_comb begin
        nz = lo_nz | hi_nz;
        if (lo_nz) begin
            idx = {1'b0, lo_idx};
        end else if (hi_nz) begin
            idx = {1'b1, hi_idx};
        end else begin
            idx = '0;
        end
    end

endmodule

// File: rtl/enc16to4_seq.sv
// enc16to4_seq
//   Sequential 16-to-4 encoder: captures a path vector and emits the select
//   code of each set bit, lowest index first, one per valid/ready handshake.
//   clk1   : clock, rising edge
//   rst1   : synchronous active-high reset
//   load   : capture request, honoured only when idle
//   path   : request vector sampled on an accepted load
//   select : index of the presented set bit
//   valid  : select is presented
//   ready  : consumer accepts select when valid
//   busy   : unserved bits are held
//   remain : unaccepted set bits, including the presented one
//   done   : one-cycle pulse when a vector is fully served (or was empty)
module enc16to4_seq
    import enc16to4_seq_pkg::*;
#(
    parameter  int unsigned limit = LIMIT,
    localparam int unsigned paths = 2 ** limit
) (
    input  logic             clk1,
    input  logic             rst1,
    input  logic             load,
    input  logic [paths-1:0] path,
    output logic [limit-1:0] select,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic [limit:0]   remain,
    output logic             done
);

    logic [0:0]       state_q,   state_d;
    logic [paths-1:0] pending_q, pending_d;
    logic [limit-1:0] select_q,  select_d;
    logic             valid_q,   valid_d;
    logic             busy_q,    busy_d;
    logic [limit:0]   remain_q,  remain_d;
    logic             done_q,    done_d;

    logic [paths-1:0] clr_mask;
    logic [limit-1:0] pri_idx;
    logic             pri_nz;

    // The encoder looks at the vector as it will be after this edge, so the
    // registered select is already the next code when valid is presented.
    enc16to4_pri u_pri (
        .vec (pending_d),
        .idx (pri_idx),
        .nz  (pri_nz)
    );

    always_comb begin
        clr_mask           = '0;
        clr_mask[select_q] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        remain_d  = remain_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    if (path != '0) begin
                        pending_d = path;
                        remain_d  = popcount(path);
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = EMIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (ready) begin
                    if (remain_q > {{limit{1'b0}}, 1'b1}) begin
                        pending_d = pending_q & ~clr_mask;
                        remain_d  = remain_q - {{limit{1'b0}}, 1'b1};
                    end else begin
                        pending_d = '0;
                        remain_d  = '0;
                        valid_d   = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
                remain_d  = '0;
                valid_d   = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // Once the vector drains, select keeps its last code.
        select_d = pri_nz ? pri_idx : select_q;
    end

    always_ff @(posedge clk1) begin
        if (rst1) begin
            state_q   <= IDLE;
            pending_q <= '0;
            select_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            remain_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            select_q  <= select_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            remain_q  <= remain_d;
            done_q    <= done_d;
        end
    end

    assign select = select_q;
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign remain = remain_q;
    assign done   = done_q;

endmodule
